// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer with a 2-bit saturating taken counter per entry.
// Latency: lookup sampled at edge N, registered prediction valid after edge N (one cycle).
// Backpressure: none; a lookup and an update may be accepted every cycle.
module branch_target_buffer #(
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] pred_next_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush
);

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
    logic [1:0]          ctr;
  } entry_t;

  entry_t                tbl [ENTRIES];
  logic [ENTRIES-1:0]    vld;

  logic [INDEX_BITS-1:0] lk_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [TAG_BITS-1:0]   upd_tag;
  entry_t                lk_e;
  entry_t                upd_e;
  entry_t                upd_next;
  logic                  lk_hit;
  logic                  upd_hit;
  logic                  upd_wr;
  logic [31:0]           lk_pc_q;
  logic                  unused_pc_bits;

  assign lk_idx  = lk_pc[INDEX_BITS+1:2];
  assign upd_idx = upd_pc[INDEX_BITS+1:2];
  assign lk_tag  = lk_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign upd_tag = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign lk_e    = tbl[lk_idx];
  assign upd_e   = tbl[upd_idx];

  // Reads see pre-update contents; a same-cycle flush forces the lookup to miss.
  assign lk_hit  = lk_valid && !flush && vld[lk_idx] && (lk_e.tag == lk_tag);
  assign upd_hit = vld[upd_idx] && (upd_e.tag == upd_tag);

  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc};

  always_comb begin
    upd_next = upd_e;
    upd_wr   = 1'b0;
    if (upd_hit) begin
      upd_wr = 1'b1;
      if (upd_taken) begin
        upd_next.ctr    = (upd_e.ctr == 2'b11) ? 2'b11 : upd_e.ctr + 2'd1;
        upd_next.target = upd_target;
      end else begin
        upd_next.ctr    = (upd_e.ctr == 2'b00) ? 2'b00 : upd_e.ctr - 2'd1;
      end
    end else if (upd_taken) begin
      upd_wr          = 1'b1;
      upd_next.tag    = upd_tag;
      upd_next.target = upd_target;
      upd_next.ctr    = 2'b10;
    end
  end

  // Payload array carries no reset; only the valid bits need clearing.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && upd_valid && upd_wr) begin
      tbl[upd_idx] <= upd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      vld <= '0;
    end else if (upd_valid && upd_wr) begin
      vld[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      lk_pc_q     <= '0;
    end else begin
      pred_valid  <= lk_valid;
      pred_hit    <= lk_hit;
      pred_taken  <= lk_hit && lk_e.ctr[1];
      pred_target <= lk_hit ? lk_e.target : 32'd0;
      lk_pc_q     <= lk_valid ? {lk_pc[31:2], 2'b00} : 32'd0;
    end
  end

  assign pred_next_pc = !pred_valid ? 32'd0 :
                        pred_taken  ? pred_target : lk_pc_q + 32'd4;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: table-driven vectors plus hand sequences
// for flush, same-cycle update/lookup and reset; expectations flow through a scoreboard queue.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        flush;

  branch_target_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lk_valid     (lk_valid),
    .lk_pc        (lk_pc),
    .pred_valid   (pred_valid),
    .pred_hit     (pred_hit),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .pred_next_pc (pred_next_pc),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [31:0] next_pc;
  } exp_t;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        utk;
    logic        lv;
    logic [31:0] lpc;
    exp_t        e;
  } vec_t;

  int     checks   = 0;
  int     failures = 0;
  string  where    = "init";
  exp_t   sb [$];
  vec_t   vec [$];

  function automatic exp_t ex(input logic h, input logic t, input logic [31:0] tg, input logic [31:0] np);
    exp_t r;
    r.hit = h; r.taken = t; r.target = tg; r.next_pc = np;
    return r;
  endfunction

  function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                              input logic utk, input logic lv, input logic [31:0] lpc, input exp_t e);
    vec_t r;
    r.uv = uv; r.upc = upc; r.utgt = utgt; r.utk = utk; r.lv = lv; r.lpc = lpc; r.e = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s %s: got %h expected %h", where, nm, act, req);
    end
  endtask

  // Drive one cycle of stimulus, then compare whatever the DUT produced for it.
  task automatic step(input logic uv, input logic [31:0] upc, input logic [31:0] utgt, input logic utk,
                      input logic lv, input logic [31:0] lpc, input logic fl, input logic rn, input exp_t e);
    exp_t got;
    upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = utk;
    lk_valid = lv; lk_pc = lpc; flush = fl; rst_n = rn;
    if (lv && rn) sb.push_back(e);
    @(posedge clk);
    #1;
    if (!rn) sb.delete();
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("pred_valid",   {31'd0, pred_valid}, 32'd1);
      chk("pred_hit",     {31'd0, pred_hit},   {31'd0, got.hit});
      chk("pred_taken",   {31'd0, pred_taken}, {31'd0, got.taken});
      chk("pred_target",  pred_target,         got.target);
      chk("pred_next_pc", pred_next_pc,        got.next_pc);
    end else begin
      chk("idle_valid",   {31'd0, pred_valid}, 32'd0);
      chk("idle_hit",     {31'd0, pred_hit},   32'd0);
      chk("idle_taken",   {31'd0, pred_taken}, 32'd0);
      chk("idle_target",  pred_target,         32'd0);
      chk("idle_next_pc", pred_next_pc,        32'd0);
    end
  endtask

  task automatic look(input logic [31:0] lpc, input exp_t e);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, lpc, 1'b0, 1'b1, e);
  endtask

  exp_t none;
  exp_t miss100;

  initial begin
    none    = ex(1'b0, 1'b0, 32'd0, 32'd0);
    miss100 = ex(1'b0, 1'b0, 32'd0, 32'h104);

    // Rows: update fields, lookup fields, expected lookup result (pre-update contents).
    vec.push_back(mk(0, 32'h0,   32'h0,   0, 1, 32'h100, miss100));
    vec.push_back(mk(1, 32'h100, 32'h80,  1, 0, 32'h0,   none));
    vec.push_back(mk(0, 32'h0,   32'h0,   0, 1, 32'h100, ex(1, 1, 32'h80, 32'h80)));
    vec.push_back(mk(1, 32'h100, 32'h444, 0, 1, 32'h100, ex(1, 1, 32'h80, 32'h80)));
    vec.push_back(mk(1, 32'h100, 32'h444, 0, 1, 32'h100, ex(1, 0, 32'h80, 32'h104)));
    vec.push_back(mk(0, 32'h0,   32'h0,   0, 1, 32'h100, ex(1, 0, 32'h80, 32'h104)));
    vec.push_back(mk(1, 32'h100, 32'h90,  1, 1, 32'h100, ex(1, 0, 32'h80, 32'h104)));
    vec.push_back(mk(1, 32'h100, 32'h90,  1, 1, 32'h100, ex(1, 0, 32'h90, 32'h104)));
    vec.push_back(mk(1, 32'h100, 32'h90,  1, 1, 32'h100, ex(1, 1, 32'h90, 32'h90)));
    vec.push_back(mk(1, 32'h100, 32'h90,  1, 1, 32'h100, ex(1, 1, 32'h90, 32'h90)));
    vec.push_back(mk(1, 32'h100, 32'h90,  0, 1, 32'h100, ex(1, 1, 32'h90, 32'h90)));
    vec.push_back(mk(1, 32'h100, 32'h90,  0, 1, 32'h100, ex(1, 1, 32'h90, 32'h90)));
    vec.push_back(mk(0, 32'h0,   32'h0,   0, 1, 32'h100, ex(1, 0, 32'h90, 32'h104)));
    vec.push_back(mk(1, 32'h140, 32'h200, 1, 1, 32'h100, ex(1, 0, 32'h90, 32'h104)));
    vec.push_back(mk(0, 32'h0,   32'h0,   0, 1, 32'h100, miss100));
    vec.push_back(mk(0, 32'h0,   32'h0,   0, 1, 32'h140, ex(1, 1, 32'h200, 32'h200)));
    vec.push_back(mk(1, 32'h180, 32'h300, 0, 1, 32'h140, ex(1, 1, 32'h200, 32'h200)));
    vec.push_back(mk(0, 32'h0,   32'h0,   0, 1, 32'h140, ex(1, 1, 32'h200, 32'h200)));
    vec.push_back(mk(0, 32'h0,   32'h0,   0, 1, 32'h180, ex(0, 0, 32'h0, 32'h184)));
    vec.push_back(mk(1, 32'h3C,  32'hFFFFFFFC, 1, 1, 32'hFFFFFFFC, ex(0, 0, 32'h0, 32'h0)));
    vec.push_back(mk(0, 32'h0,   32'h0,   0, 1, 32'h3C,  ex(1, 1, 32'hFFFFFFFC, 32'hFFFFFFFC)));
    vec.push_back(mk(0, 32'h0,   32'h0,   0, 0, 32'h0,   none));

    // Reset state: a lookup presented under reset yields no response.
    where = "reset";
    step(0, 32'd0, 32'd0, 0, 1, 32'h100, 0, 0, none);
    step(0, 32'd0, 32'd0, 0, 0, 32'h0,   0, 0, none);

    for (int i = 0; i < vec.size(); i++) begin
      where = $sformatf("vec%0d", i);
      step(vec[i].uv, vec[i].upc, vec[i].utgt, vec[i].utk, vec[i].lv, vec[i].lpc, 1'b0, 1'b1, vec[i].e);
    end

    // Flush drops the same-cycle update and forces the same-cycle lookup to miss.
    where = "flush";
    step(1, 32'h200, 32'h500, 1, 1, 32'h140, 1, 1, ex(0, 0, 32'h0, 32'h144));
    look(32'h140, ex(0, 0, 32'h0, 32'h144));
    look(32'h3C,  ex(0, 0, 32'h0, 32'h40));
    look(32'h200, ex(0, 0, 32'h0, 32'h204));

    // Same-cycle update and lookup on an empty table: lookup sees the old (empty) entry.
    where = "same_cycle";
    step(1, 32'h100, 32'h80, 1, 1, 32'h100, 0, 1, miss100);
    look(32'h100, ex(1, 1, 32'h80, 32'h80));

    // Back-to-back lookups, then reset arriving with a lookup pending.
    where = "rst_mid";
    look(32'h100, ex(1, 1, 32'h80, 32'h80));
    step(0, 32'd0, 32'd0, 0, 1, 32'h100, 0, 0, none);
    where = "post_rst";
    look(32'h100, miss100);
    step(0, 32'd0, 32'd0, 0, 0, 32'h0, 0, 1, none);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
